// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned ITER_DEF   = 32;
    localparam logic        OP_MULT    = 1'b0;
    localparam logic        OP_DIV     = 1'b1;
    localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between main control (master) and muldiv_ctrl (slave).
interface muldiv_if;

    logic        start;
    logic        op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, div_zero, HI, LO
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, div_zero, HI, LO
    );

endinterface

// File: rtl/muldiv_core.sv
// Unsigned datapath: shift-add multiply and restoring divide, one step per cycle.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        op,
    input  logic [31:0] acc_init,
    input  logic [31:0] opnd_init,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] acc;
    logic [31:0] opnd;
    logic [32:0] a33;
    logic [32:0] b33;
    logic [32:0] sum;

    // Divide subtracts from the shifted partial remainder; multiply adds to the upper half.
    always_comb begin
        a33 = (op == OP_DIV) ? acc[63:31] : {1'b0, acc[63:32]};
        b33 = (op == OP_DIV) ? ~{1'b0, opnd} : {1'b0, opnd};
        sum = a33 + b33 + {32'b0, op};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {32'b0, acc_init};
            opnd <= opnd_init;
        end else if (step) begin
            if (op == OP_DIV) begin
                if (!sum[32]) acc <= {sum[31:0], acc[30:0], 1'b1};
                else          acc <= {acc[62:0], 1'b0};
            end else begin
                if (acc[0]) acc <= {sum, acc[31:1]};
                else        acc <= {1'b0, acc[63:1]};
            end
        end
    end

    assign hi = acc[63:32];
    assign lo = acc[31:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for MULT/DIV: operand capture, sign handling, div-by-zero bypass, HI/LO.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEF
)(
    input  logic      clk,
    input  logic      reset,
    muldiv_if.slave   bus
);

    localparam int unsigned CW = $clog2(ITER + 1);

    state_t       state;
    logic [CW-1:0] cnt;
    logic         op_q;
    logic [31:0]  rs_q;
    logic [31:0]  rt_q;
    logic         neg_rs;
    logic         neg_rt;

    logic [31:0]  mag_rs;
    logic [31:0]  mag_rt;
    logic [31:0]  core_hi;
    logic [31:0]  core_lo;
    logic         core_load;
    logic         core_step;
    logic [63:0]  prod_fix;
    logic [31:0]  quot_fix;
    logic [31:0]  rem_fix;

    always_comb begin
        mag_rs    = rs_q[31] ? -rs_q : rs_q;
        mag_rt    = rt_q[31] ? -rt_q : rt_q;
        core_load = (state == LOAD);
        core_step = (state == RUN);
        prod_fix  = (neg_rs ^ neg_rt) ? -{core_hi, core_lo} : {core_hi, core_lo};
        quot_fix  = (neg_rs ^ neg_rt) ? -core_lo : core_lo;
        rem_fix   = neg_rs ? -core_hi : core_hi;
    end

    muldiv_core u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (core_load),
        .step      (core_step),
        .op        (op_q),
        .acc_init  ((op_q == OP_DIV) ? mag_rs : mag_rt),
        .opnd_init ((op_q == OP_DIV) ? mag_rt : mag_rs),
        .hi        (core_hi),
        .lo        (core_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= OP_MULT;
            rs_q         <= '0;
            rt_q         <= '0;
            neg_rs       <= 1'b0;
            neg_rt       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.HI       <= '0;
            bus.LO       <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        rs_q     <= bus.rs_val;
                        rt_q     <= bus.rt_val;
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                LOAD: begin
                    neg_rs <= rs_q[31];
                    neg_rt <= rt_q[31];
                    if (op_q == OP_DIV && rt_q == '0) begin
                        bus.HI       <= rs_q;
                        bus.LO       <= DIVZERO_LO;
                        bus.div_zero <= 1'b1;
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= DONE;
                    end else begin
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    if (op_q == OP_DIV) begin
                        bus.HI <= rem_fix;
                        bus.LO <= quot_fix;
                    end else begin
                        bus.HI <= prod_fix[63:32];
                        bus.LO <= prod_fix[31:0];
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= DONE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed and random ops against a signed-arithmetic model.
module tb_muldiv_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_if bus ();

    muldiv_ctrl #(.ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (op == 1'b0) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Called at a negedge; drives a request, follows it to done and checks everything on the way.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input int inject, input bit chain,
                          input logic nop, input logic [31:0] na, input logic [31:0] nb,
                          input string name);
        logic [31:0] eh, el;
        logic        edz;
        int          want_lat;
        bit          seen;
        model(op, a, b, eh, el, edz);
        want_lat = (op == 1'b1 && b == 32'd0) ? 2 : 35;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.op     = 1'($urandom_range(0, 1));
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            @(negedge clk);
            if (inject > 0 && cyc == inject + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                total++;
                if (cyc !== want_lat) begin
                    bad++;
                    $display("FAIL %s latency: got %0d want %0d", name, cyc, want_lat);
                end
                total++;
                if (bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s busy_at_done: got %b want 0", name, bus.busy);
                end
                total++;
                if (bus.div_zero !== edz) begin
                    bad++;
                    $display("FAIL %s div_zero: got %b want %b", name, bus.div_zero, edz);
                end
                total++;
                if (bus.HI !== eh) begin
                    bad++;
                    $display("FAIL %s HI: got %h want %h", name, bus.HI, eh);
                end
                total++;
                if (bus.LO !== el) begin
                    bad++;
                    $display("FAIL %s LO: got %h want %h", name, bus.LO, el);
                end
                exp_hi = eh;
                exp_lo = el;
                if (chain) begin
                    bus.start  = 1'b1;
                    bus.op     = nop;
                    bus.rs_val = na;
                    bus.rt_val = nb;
                end else begin
                    bus.start = 1'b0;
                end
            end else begin
                total++;
                if (bus.busy !== 1'b1 || bus.div_zero !== 1'b0) begin
                    bad++;
                    $display("FAIL %s busy cycle %0d: busy=%b dz=%b want busy=1 dz=0",
                             name, cyc, bus.busy, bus.div_zero);
                end
                total++;
                if (bus.HI !== exp_hi || bus.LO !== exp_lo) begin
                    bad++;
                    $display("FAIL %s hold cycle %0d: got %h:%h want %h:%h",
                             name, cyc, bus.HI, bus.LO, exp_hi, exp_lo);
                end
                if (cyc == inject) begin
                    bus.start  = 1'b1;
                    bus.op     = 1'($urandom_range(0, 1));
                    bus.rs_val = $urandom;
                    bus.rt_val = $urandom;
                end
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got no done want done by cycle %0d", name, want_lat);
        end else if (!chain) begin
            @(negedge clk);
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL %s idle_after: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 1'b0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset flags: busy=%b done=%b dz=%b want 0 0 0", bus.busy, bus.done, bus.div_zero);
        end
        total++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            bad++;
            $display("FAIL reset hilo: got %h:%h want 0:0", bus.HI, bus.LO);
        end
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_div();
        run_op(1'b1, 32'd7, 32'd2, 0, 1'b0, 1'b0, '0, '0, "div_7_2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0, '0, '0, "div_m7_2");
    endtask

    task automatic test_mult();
        run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 1'b0, '0, '0, "mult_m1_2");
        run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1'b0, 1'b0, '0, '0, "mult_max");
    endtask

    task automatic test_divzero();
        run_op(1'b1, 32'd5, 32'd0, 0, 1'b0, 1'b0, '0, '0, "div_5_0");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, '0, '0, "div_min_m1");
    endtask

    task automatic test_ignore_start();
        run_op(1'b0, 32'd12345, 32'hFFFF_FFB3, 10, 1'b0, 1'b0, '0, '0, "ign_run");
        run_op(1'b1, 32'hDEAD_BEEF, 32'd1234, 34, 1'b0, 1'b0, '0, '0, "ign_fix");
        run_op(1'b1, 32'd99, 32'd0, 1, 1'b0, 1'b0, '0, '0, "ign_load_dz");
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 32'd100, 32'd7, 0, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd9, "b2b_0");
        run_op(1'b0, 32'hFFFF_FFFD, 32'd9, 0, 1'b1, 1'b1, 32'd42, 32'd0, "b2b_1");
        run_op(1'b1, 32'd42, 32'd0, 0, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "b2b_2");
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, 1'b0, '0, '0, "b2b_3");
    endtask

    task automatic test_reset_mid();
        int dones;
        bus.start  = 1'b1;
        bus.op     = 1'b1;
        bus.rs_val = 32'd1000;
        bus.rt_val = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid flags: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        total++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid hilo: got %h:%h want 0:0", bus.HI, bus.LO);
        end
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        dones  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL rst_mid activity: got %0d active cycles want 0", dones);
        end
    endtask

    task automatic test_random();
        logic        ops [0:24];
        logic [31:0] as  [0:24];
        logic [31:0] bs  [0:24];
        int          inj;
        bit          ch;
        for (int i = 0; i < 25; i++) begin
            ops[i] = 1'($urandom_range(0, 1));
            as[i]  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       bs[i] = 32'd0;
                1:       bs[i] = 32'hFFFF_FFFF;
                2:       bs[i] = 32'($urandom_range(1, 20));
                default: bs[i] = $urandom;
            endcase
        end
        for (int i = 0; i < 25; i++) begin
            if (ops[i] == 1'b1 && bs[i] == 32'd0) inj = int'($urandom_range(0, 1));
            else inj = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 34));
            ch = (i < 24) && ($urandom_range(0, 1) == 1);
            if (ch) run_op(ops[i], as[i], bs[i], inj, 1'b1, ops[i+1], as[i+1], bs[i+1], "rand");
            else    run_op(ops[i], as[i], bs[i], inj, 1'b0, 1'b0, '0, '0, "rand");
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        test_reset();
        test_div();
        test_mult();
        test_divzero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the processor's iterative multiply/divide unit. Accepts a MULT or DIV request from the main control FSM and captures both operands. Drives a 32-iteration shift-add / restoring-divide core and handles signs and divide-by-zero. Writes the HI/LO register pair, and raises `busy` so main control stalls MFHI/MFLO and further mult/div instructions until the result is committed.

## Interface

Parameters:
- `ITER`, 32: iterations per operation; equals operand width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; returns block to IDLE.
- `start`  in  1  request strobe from main control; sampled only in IDLE or DONE.
- `op`  in  1  0 = MULT (signed), 1 = DIV (signed).
- `rs_val`  in  32  multiplicand / dividend.
- `rt_val`  in  32  multiplier / divisor.
- `busy`  out  1  operation in flight; main control must stall.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_zero`  out  1  pulses with `done` when a DIV had divisor 0.
- `HI`  out  32  high product word / remainder.
- `LO`  out  32  low product word / quotient.

## Operation

- Reset values: `HI` = 0, `LO` = 0, `busy` = 0, `done` = 0, `div_zero` = 0, state IDLE, iteration counter 0.
- Operation states and transitions:
  - IDLE: on `start`, latch `op`/`rs_val`/`rt_val`, go to LOAD. Otherwise stay in IDLE.
  - LOAD: record operand signs and load absolute values into the core.
    - DIV with `rt_val` = 0: go straight to DONE.
    - Otherwise: clear the counter, go to RUN.
  - RUN: one core step per cycle; counter increments. After step `ITER`, go to FIX.
  - FIX: apply signs and register `HI`/`LO`, then go to DONE.
  - DONE: `done` = 1. A `start` here is accepted exactly as in IDLE (goes to LOAD); otherwise go to IDLE.
- `busy` = 1 in LOAD, RUN and FIX only.
- `start` in any other state is ignored, with no side effects.
- MULT: unsigned 32×32 shift-add on magnitudes, giving a 64-bit result. Negate the result if the operand signs differ. `HI:LO` = product.
- DIV: restoring division on magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - `LO` = quotient, `HI` = remainder.
  - Magnitudes are treated as 32-bit unsigned, so |0x80000000| = 0x80000000.
  - 0x80000000 / −1 gives `LO` = 0x80000000, `HI` = 0. No trap.
- Divide-by-zero: `HI` = `rs_val`, `LO` = 0xFFFFFFFF, `div_zero` = 1 during DONE.
- `HI`/`LO` change only on the edge entering DONE. In all other states they hold their previous value.
- Reset mid-operation: the in-flight result is discarded, `HI`/`LO` return to 0, and no `done` pulse is produced.

## Timing

- E0 = the edge at which `start` is sampled.
- Normal latency:
  - LOAD: cycle 1.
  - RUN: cycles 2–33.
  - FIX: cycle 34.
  - DONE: cycle 35, with `done` = 1 and `HI`/`LO` valid.
- Divide-by-zero latency: LOAD at cycle 1, DONE at cycle 2.
- `busy` rises in cycle 1 and falls in the cycle `done` is high.
- Back-to-back: `start` in a DONE cycle makes the next cycle LOAD. No idle bubble.
- Operands are latched at E0; later changes on `rs_val`/`rt_val` have no effect.

## Structure

- Shared package `muldiv_pkg` holds:
  - `op` encodings `OP_MULT` / `OP_DIV`.
  - State enum IDLE/LOAD/RUN/FIX/DONE.
  - `ITER` default.
  - `DIVZERO_LO` = 32'hFFFFFFFF.
- Sub-module `muldiv_core` owns the datapath and exposes no FSM:
  - the 64-bit shift registers for remainder/product and divisor/multiplicand;
  - the step adder/subtractor;
  - the `load` and `step` enables and the `op` select.
- `muldiv_ctrl` owns the FSM, the counter, sign capture/fix-up, the divide-by-zero bypass and the `HI`/`LO` registers.

## Test plan

- DIV 7 / 2 → cycle 35: `LO` = 3, `HI` = 1, `done` = 1, `div_zero` = 0, `busy` high in cycles 1–34.
- DIV −7 (0xFFFFFFF9) / 2 → `LO` = 0xFFFFFFFD, `HI` = 0xFFFFFFFF.
- MULT 0xFFFFFFFF × 2 → `HI` = 0xFFFFFFFF, `LO` = 0xFFFFFFFE. Then MULT 0x7FFFFFFF × 0x7FFFFFFF → `HI` = 0x3FFFFFFF, `LO` = 0x00000001.
- DIV 5 / 0 → cycle 2: `done` = 1, `div_zero` = 1, `HI` = 5, `LO` = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `LO` = 0x80000000, `HI` = 0.
- `start` pulsed during RUN with different operands → ignored, original result returned. `start` held in DONE → next op enters LOAD the following cycle, completes 35 cycles later.
- `reset` asserted in RUN cycle 10 → next cycle: IDLE, `busy` = 0, `HI` = `LO` = 0, no `done` pulse.
